branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 123 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch resolve queue with mispredict flush
module branch_resolve_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  logic [31:0] enq_pc,
    input  logic        enq_pred_taken,
    input  logic [31:0] enq_pred_target,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic [7:0]  o_pendingB_8,
    output logic        fix_valid,
    output logic [31:0] fix_pc,
    output logic [7:0]  fix_pendingB_8,
    output logic [15:0] mispredict_cnt_16,
    output logic        err_underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t         state;
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [7:0]     count;

    logic [31:0]    pc_mem     [DEPTH];
    logic           taken_mem  [DEPTH];
    logic [31:0]    target_mem [DEPTH];

    logic [31:0]    head_pc;
    logic           head_taken;
    logic [31:0]    head_target;
    logic           push;
    logic           res_accept;
    logic           mispredict;
    logic           pop;
    logic           push_keep;

    assign head_pc     = pc_mem[head];
    assign head_taken  = taken_mem[head];
    assign head_target = target_mem[head];

    // Ready depends only on registered state so fetch never sees a path from execute.
    assign enq_ready  = (state == RUN) && (count < DEPTH8);
    assign push       = enq_valid && enq_ready;
    assign res_accept = (state == RUN) && res_valid && (count != 8'd0);
    assign mispredict = res_accept &&
                        ((res_taken != head_taken) ||
                         (res_taken && head_taken && (res_target != head_target)));
    assign pop        = res_accept && !mispredict;
    // A push alongside a mispredict is on the wrong path and is dropped.
    assign push_keep  = push && !mispredict;

    assign o_pendingB_8 = count;

    always_ff @(posedge clk) begin
        if (push_keep) begin
            pc_mem[tail]     <= enq_pc;
            taken_mem[tail]  <= enq_pred_taken;
            target_mem[tail] <= enq_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= RUN;
            head              <= '0;
            tail              <= '0;
            count             <= 8'd0;
            fix_valid         <= 1'b0;
            fix_pc            <= 32'd0;
            fix_pendingB_8    <= 8'd0;
            mispredict_cnt_16 <= 16'd0;
            err_underflow     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (res_valid && (count == 8'd0)) begin
                        err_underflow <= 1'b1;
                    end
                    if (mispredict) begin
                        state          <= FLUSH;
                        head           <= '0;
                        tail           <= '0;
                        count          <= 8'd0;
                        fix_valid      <= 1'b1;
                        fix_pc         <= res_taken ? res_target : head_pc + 32'd4;
                        fix_pendingB_8 <= count;
                        if (mispredict_cnt_16 != 16'hFFFF) begin
                            mispredict_cnt_16 <= mispredict_cnt_16 + 16'd1;
                        end
                    end else begin
                        fix_valid <= 1'b0;
                        if (pop) begin
                            head <= head + AW'(1);
                        end
                        if (push_keep) begin
                            tail <= tail + AW'(1);
                        end
                        case ({push_keep, pop})
                            2'b10:   count <= count + 8'd1;
                            2'b01:   count <= count - 8'd1;
                            default: count <= count;
                        endcase
                    end
                end
                FLUSH: begin
                    state     <= RUN;
                    fix_valid <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - vector table, directed corners and random model check
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_pc = 32'd0;
    logic        enq_pred_taken = 1'b0;
    logic [31:0] enq_pred_target = 32'd0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = 32'd0;
    logic [7:0]  o_pendingB_8;
    logic        fix_valid;
    logic [31:0] fix_pc;
    logic [7:0]  fix_pendingB_8;
    logic [15:0] mispredict_cnt_16;
    logic        err_underflow;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
        .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .o_pendingB_8(o_pendingB_8), .fix_valid(fix_valid), .fix_pc(fix_pc),
        .fix_pendingB_8(fix_pendingB_8), .mispredict_cnt_16(mispredict_cnt_16),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t        mq[$];
    bit          m_flush;
    bit          m_fv;
    logic [31:0] m_fpc;
    logic [7:0]  m_fpend;
    int          m_mcnt;
    bit          m_err;

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic [7:0]  e_cnt;
        logic        e_fv;
        logic [31:0] e_fpc;
        logic [7:0]  e_fpend;
        logic        e_rdy;
        logic [15:0] e_mcnt;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush = 0;
        m_fv = 0;
        m_fpc = 32'd0;
        m_fpend = 8'd0;
        m_mcnt = 0;
        m_err = 0;
    endtask

    task automatic do_reset();
        enq_valid = 1'b0;
        res_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic model_compare(input string tag);
        check({tag, "_ready"}, enq_ready, (!m_flush && mq.size() < DEPTH) ? 1 : 0);
        check({tag, "_count"}, o_pendingB_8, mq.size());
        check({tag, "_fix_valid"}, fix_valid, m_fv);
        if (m_fv) begin
            check({tag, "_fix_pc"}, fix_pc, m_fpc);
            check({tag, "_fix_pend"}, fix_pendingB_8, m_fpend);
        end
        check({tag, "_mcnt"}, mispredict_cnt_16, m_mcnt);
        check({tag, "_err"}, err_underflow, m_err);
    endtask

    // Drive one cycle of inputs, advance the model by the queue rules, compare after the edge.
    task automatic cycle(input logic ev, input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptg, input logic rv, input logic rt,
                         input logic [31:0] rtg, input string tag);
        bit   rdy;
        bit   mis;
        ent_t h;
        enq_valid = ev; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        rdy = !m_flush && (mq.size() < DEPTH);
        mis = 0;
        if (m_flush) begin
            m_flush = 0;
            m_fv = 0;
        end else begin
            m_fv = 0;
            if (rv && mq.size() == 0) m_err = 1;
            if (rv && mq.size() != 0) begin
                h = mq[0];
                mis = (rt != h.taken) || (rt && h.taken && rtg != h.target);
                if (mis) begin
                    m_fv = 1;
                    m_fpc = rt ? rtg : h.pc + 32'd4;
                    m_fpend = 8'(mq.size());
                    if (m_mcnt < 65535) m_mcnt++;
                    mq.delete();
                    m_flush = 1;
                end else begin
                    void'(mq.pop_front());
                end
            end
            if (!mis && ev && rdy) mq.push_back('{pc, pt, ptg});
        end
        @(posedge clk);
        #1;
        model_compare(tag);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd1, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[1]  = '{1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd2, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd3, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[3]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   8'd2, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[4]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   8'd1, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   8'd0, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[6]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd1, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[7]  = '{1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd2, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[8]  = '{1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd3, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[9]  = '{1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd4, 1'b0, 32'h0,   8'd0, 1'b1, 16'd0};
        tbl[10] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 8'd0, 1'b1, 32'h400, 8'd4, 1'b0, 16'd1};
        tbl[11] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd0, 1'b0, 32'h0,   8'd0, 1'b1, 16'd1};
        tbl[12] = '{1'b1, 32'h700, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0,   8'd1, 1'b0, 32'h0,   8'd0, 1'b1, 16'd1};
        tbl[13] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   8'd0, 1'b1, 32'h704, 8'd1, 1'b0, 16'd2};
        tbl[14] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   8'd0, 1'b0, 32'h0,   8'd0, 1'b1, 16'd2};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_fix_valid", fix_valid, 0);
        check("rst_fix_pc", fix_pc, 0);
        check("rst_fix_pend", fix_pendingB_8, 0);
        check("rst_count", o_pendingB_8, 0);
        check("rst_mcnt", mispredict_cnt_16, 0);
        check("rst_err", err_underflow, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ready_first_cycle", enq_ready, 1);

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].ev, tbl[i].pc, tbl[i].pt, tbl[i].ptg,
                  tbl[i].rv, tbl[i].rt, tbl[i].rtg, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_count_k", i), o_pendingB_8, tbl[i].e_cnt);
            check($sformatf("tbl%0d_fv_k", i), fix_valid, tbl[i].e_fv);
            check($sformatf("tbl%0d_ready_k", i), enq_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d_mcnt_k", i), mispredict_cnt_16, tbl[i].e_mcnt);
            if (tbl[i].e_fv) begin
                check($sformatf("tbl%0d_fpc_k", i), fix_pc, tbl[i].e_fpc);
                check($sformatf("tbl%0d_fpend_k", i), fix_pendingB_8, tbl[i].e_fpend);
            end
        end

        // Fill to capacity, push while full, then push+resolve at count 7.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "fill");
        check("full_ready", enq_ready, 0);
        check("full_count", o_pendingB_8, 8);
        cycle(1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "ninth");
        check("ninth_count", o_pendingB_8, 8);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "pop7");
        check("pop7_count", o_pendingB_8, 7);
        cycle(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "pushpop");
        check("pushpop_count", o_pendingB_8, 7);
        for (int i = 0; i < 7; i++)
            cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "drain");
        check("drain_count", o_pendingB_8, 0);

        // Taken with wrong target, concurrent push dropped.
        do_reset();
        cycle(1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, "tgt_push");
        cycle(1'b1, 32'h200, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600, "tgt_res");
        check("tgt_fix_valid", fix_valid, 1);
        check("tgt_fix_pc", fix_pc, 32'h600);
        check("tgt_count", o_pendingB_8, 0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "tgt_after");
        check("tgt_after_count", o_pendingB_8, 0);
        check("tgt_after_fv", fix_valid, 0);

        // Underflow is sticky; then reset in the middle of FLUSH.
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, "uf");
        check("uf_err", err_underflow, 1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "uf_hold");
        check("uf_sticky", err_underflow, 1);
        cycle(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "mf_push");
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h800, "mf_res");
        check("mf_fv_before", fix_valid, 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("mf_fv_abort", fix_valid, 0);
        check("mf_fix_pc", fix_pc, 0);
        check("mf_fix_pend", fix_pendingB_8, 0);
        check("mf_count", o_pendingB_8, 0);
        check("mf_mcnt", mispredict_cnt_16, 0);
        check("mf_err", err_underflow, 0);
        check("mf_ready", enq_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "mf_post");
        check("mf_post_fv", fix_valid, 0);

        // Random traffic against the queue model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        ev, pt, rv, rt;
            logic [31:0] pc, ptg, rtg;
            ev  = ($urandom_range(0, 9) < 6);
            pc  = $urandom & 32'hFFFF_FFFC;
            pt  = $urandom_range(0, 1);
            ptg = ($urandom_range(0, 1) != 0) ? 32'h500 : 32'h600;
            rv  = ($urandom_range(0, 9) < 4);
            if (mq.size() != 0 && $urandom_range(0, 7) != 0) begin
                rt  = mq[0].taken;
                rtg = mq[0].target;
            end else begin
                rt  = $urandom_range(0, 1);
                rtg = ($urandom_range(0, 1) != 0) ? 32'h500 : 32'h600;
            end
            cycle(ev, pc, pt, ptg, rv, rt, rtg, "rnd");
            if (n % 1000 == 999) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
